// File: rtl/dense_weight_stream_loader.sv
// dense_weight_stream_loader: packs a valid/ready stream of weight beats
// into full rows, writes them to an on-chip RAM, serves 2-stage reads.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   data_in[]         one beat of BEAT_ELEMS weight elements
//   data_in_valid     beat valid
//   data_in_ready     loader accepts beats (high while loading)
//   reload            restart loading at row 0, beat 0 (drops same-cycle beat)
//   load_done         all ROW_DEPTH rows written
//   rows_loaded       rows written since last reset/reload
//   rd_addr, rd_en    row read address and read-pipeline enable
//   rd_data           row read data, 2 enabled cycles after rd_addr
module dense_weight_stream_loader #(
    parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
    parameter int WEIGHT_PRECISION_0       = 16,
    parameter int WEIGHT_PARALLELISM_DIM_0 = 4,
    parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
    parameter int ROW_DEPTH                = 8,
    parameter int BEAT_ELEMS    =
        WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1,
    parameter int BEATS_PER_ROW =
        WEIGHT_TENSOR_SIZE_DIM_0 / BEAT_ELEMS,
    parameter int ROW_WIDTH     =
        WEIGHT_PRECISION_0 * WEIGHT_TENSOR_SIZE_DIM_0,
    parameter int AWIDTH        = $clog2(ROW_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WEIGHT_PRECISION_0-1:0] data_in [BEAT_ELEMS],
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    input  logic                          reload,
    output logic                          load_done,
    output logic [AWIDTH-1:0]             rows_loaded,
    input  logic [AWIDTH-1:0]             rd_addr,
    input  logic                          rd_en,
    output logic [ROW_WIDTH-1:0]          rd_data
);

    localparam int BEAT_W = WEIGHT_PRECISION_0 * BEAT_ELEMS;
    localparam int BW =
        (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int IW =
        (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_ROW - 1);
    localparam logic [IW-1:0] LAST_ROW  = IW'(ROW_DEPTH - 1);

    if (BEATS_PER_ROW * BEAT_ELEMS != WEIGHT_TENSOR_SIZE_DIM_0)
    begin : g_bad_cfg
        $error("row size must be a whole number of beats");
    end

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t               state;
    logic [BW-1:0]        beat_cnt;
    logic [IW-1:0]        row_cnt;
    logic [BEAT_W-1:0]    beat_flat;
    logic [ROW_WIDTH-1:0] wr_row;
    logic                 xfer;
    logic                 last_beat;
    logic                 row_wr;
    logic                 rd_in_range;
    logic [ROW_WIDTH-1:0] ram [ROW_DEPTH];
    logic [ROW_WIDTH-1:0] rd_s0;
    logic [ROW_WIDTH-1:0] rd_s1;

    assign data_in_ready = (state == LOAD);
    // reload wins over a beat presented in the same cycle
    assign xfer      = data_in_valid && data_in_ready && !reload;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign row_wr    = xfer && last_beat;
    assign rd_data   = rd_s1;
    assign rd_in_range = (rd_addr < AWIDTH'(ROW_DEPTH));

    always_comb begin
        beat_flat = '0;
        for (int j = 0; j < BEAT_ELEMS; j++) begin
            beat_flat[j*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0] =
                data_in[j];
        end
    end

    // The final beat is merged with the buffered beats on the fly,
    // so a row lands in RAM on the same edge its last beat is taken.
    if (BEATS_PER_ROW > 1) begin : g_buf
        logic [ROW_WIDTH-BEAT_W-1:0] row_buf;

        always_ff @(posedge clk) begin
            if (xfer && !last_beat) begin
                row_buf[int'(beat_cnt)*BEAT_W +: BEAT_W] <= beat_flat;
            end
        end

        assign wr_row = {beat_flat, row_buf};
    end else begin : g_nobuf
        assign wr_row = beat_flat;
    end

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            state       <= LOAD;
            beat_cnt    <= '0;
            row_cnt     <= '0;
            rows_loaded <= '0;
            load_done   <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (xfer) begin
                        if (last_beat) begin
                            beat_cnt    <= '0;
                            rows_loaded <= rows_loaded + 1'b1;
                            if (row_cnt == LAST_ROW) begin
                                row_cnt   <= '0;
                                state     <= DONE;
                                load_done <= 1'b1;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // RAM contents survive reset and reload by design
    always_ff @(posedge clk) begin
        if (row_wr) begin
            ram[row_cnt] <= wr_row;
        end
    end

    // Nonblocking read of ram gives read-first behaviour on collision
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_s0 <= '0;
            rd_s1 <= '0;
        end else if (rd_en) begin
            rd_s0 <= rd_in_range ? ram[rd_addr[IW-1:0]] : '0;
            rd_s1 <= rd_s0;
        end
    end

endmodule

// File: tb/tb_dense_weight_stream_loader.sv
// tb_dense_weight_stream_loader: directed stimulus with a read
// scoreboard for dense_weight_stream_loader (8x16b rows, 2-elem beats).
module tb_dense_weight_stream_loader;

    localparam int P   = 16;
    localparam int TS0 = 8;
    localparam int BE  = 2;
    localparam int RD  = 3;
    localparam int RW  = P * TS0;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [P-1:0]  data_in [BE];
    logic          data_in_valid;
    logic          data_in_ready;
    logic          reload;
    logic          load_done;
    logic [AW-1:0] rows_loaded;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [RW-1:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [RW-1:0] exp_q [$];
    logic rq;
    logic t0;
    logic fresh;

    dense_weight_stream_loader #(
        .WEIGHT_TENSOR_SIZE_DIM_0(TS0),
        .WEIGHT_PRECISION_0(P),
        .WEIGHT_PARALLELISM_DIM_0(2),
        .WEIGHT_PARALLELISM_DIM_1(1),
        .ROW_DEPTH(RD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .reload(reload),
        .load_done(load_done),
        .rows_loaded(rows_loaded),
        .rd_addr(rd_addr),
        .rd_en(rd_en),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [RW-1:0] act,
                           input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] make_row(input int base,
                                               input int r);
        logic [RW-1:0] row;
        row = '0;
        for (int e = 0; e < TS0; e++) begin
            row[e*P +: P] = 16'(base + r*TS0 + e);
        end
        return row;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int base, input int k);
        for (int j = 0; j < BE; j++) begin
            data_in[j] = 16'(base + k*BE + j);
        end
    endtask

    task automatic load_all(input int base);
        for (int k = 0; k < RD*4; k++) begin
            set_beat(base, k);
            data_in_valid = 1'b1;
            tick();
        end
        data_in_valid = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [RW-1:0] exp);
        rd_addr = AW'(addr);
        rq = 1'b1;
        exp_q.push_back(exp);
        tick();
        rq = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    // Track issued reads through the DUT's rd_en-gated pipeline
    always @(posedge clk) begin
        if (rst) begin
            t0    <= 1'b0;
            fresh <= 1'b0;
        end else begin
            fresh <= rd_en && t0;
            if (rd_en) t0 <= rq;
        end
    end

    always @(negedge clk) begin
        if (fresh) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got %h", rd_data);
            end else begin
                chk_row("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        int acc;
        rst = 1'b1;
        data_in_valid = 1'b0;
        reload = 1'b0;
        rd_en = 1'b1;
        rq = 1'b0;
        rd_addr = '0;
        data_in[0] = '0;
        data_in[1] = '0;
        repeat (2) tick();
        chk("rst_ready", 32'(data_in_ready), 1);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_rows", 32'(rows_loaded), 0);
        chk_row("rst_rd_data", rd_data, '0);
        rst = 1'b0;
        tick();

        // full load, valid every cycle
        for (int k = 0; k < RD*4; k++) begin
            set_beat(0, k);
            data_in_valid = 1'b1;
            tick();
            if (k == 10) begin
                chk("full_pre_done", 32'(load_done), 0);
                chk("full_pre_ready", 32'(data_in_ready), 1);
                chk("full_pre_rows", 32'(rows_loaded), 2);
            end
        end
        data_in_valid = 1'b0;
        chk("full_done", 32'(load_done), 1);
        chk("full_ready", 32'(data_in_ready), 0);
        chk("full_rows", 32'(rows_loaded), 3);
        rd(1, {16'h000F, 16'h000E, 16'h000D, 16'h000C,
               16'h000B, 16'h000A, 16'h0009, 16'h0008});
        rd(0, make_row(0, 0));
        rd(2, make_row(0, 2));
        repeat (3) tick();

        // valid held in DONE must not be accepted
        data_in[0] = 16'hDEAD;
        data_in[1] = 16'hDEAD;
        data_in_valid = 1'b1;
        repeat (5) tick();
        data_in_valid = 1'b0;
        chk("done_ready", 32'(data_in_ready), 0);
        chk("done_rows", 32'(rows_loaded), 3);
        chk("done_done", 32'(load_done), 1);
        for (int r = 0; r < RD; r++) rd(r, make_row(0, r));
        repeat (3) tick();

        // bursty valid 1,0,0,1,0,0 ...
        pulse_reload();
        chk("rel_rows", 32'(rows_loaded), 0);
        chk("rel_ready", 32'(data_in_ready), 1);
        chk("rel_done", 32'(load_done), 0);
        acc = 0;
        for (int cyc = 0; cyc < 100 && acc < RD*4; cyc++) begin
            if (cyc % 3 == 0) begin
                set_beat(0, acc);
                data_in_valid = 1'b1;
            end else begin
                data_in[0] = 16'hFFFF;
                data_in[1] = 16'hFFFF;
                data_in_valid = 1'b0;
            end
            tick();
            if (data_in_valid) acc++;
            chk("burst_rows", 32'(rows_loaded), 32'(acc/4));
        end
        data_in_valid = 1'b0;
        chk("burst_beats", 32'(acc), 12);
        chk("burst_done", 32'(load_done), 1);
        for (int r = 0; r < RD; r++) rd(r, make_row(0, r));
        repeat (3) tick();

        // reload mid-row with a beat in the same cycle
        pulse_reload();
        for (int k = 0; k < 6; k++) begin
            set_beat(16'h200, k);
            data_in_valid = 1'b1;
            tick();
        end
        chk("mid_rows", 32'(rows_loaded), 1);
        data_in[0] = 16'hBEEF;
        data_in[1] = 16'hBEEF;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        data_in_valid = 1'b0;
        chk("mid_rel_rows", 32'(rows_loaded), 0);
        chk("mid_rel_ready", 32'(data_in_ready), 1);

        // fresh load; collide a read of row 2 with its write
        for (int k = 0; k < RD*4; k++) begin
            set_beat(16'h100, k);
            data_in_valid = 1'b1;
            if (k == RD*4-1) begin
                rd_addr = 3'd2;
                rq = 1'b1;
                exp_q.push_back(make_row(0, 2));
            end
            tick();
            rq = 1'b0;
        end
        data_in_valid = 1'b0;
        rd(2, make_row(16'h100, 2));
        rd(0, make_row(16'h100, 0));
        rd(1, make_row(16'h100, 1));
        repeat (3) tick();
        chk("fresh_done", 32'(load_done), 1);

        // reset after 5 beats, then a stalled read
        pulse_reload();
        for (int k = 0; k < 5; k++) begin
            set_beat(16'h300, k);
            data_in_valid = 1'b1;
            tick();
        end
        data_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ready", 32'(data_in_ready), 1);
        chk("mrst_done", 32'(load_done), 0);
        chk("mrst_rows", 32'(rows_loaded), 0);
        chk_row("mrst_rd_data", rd_data, '0);
        rd_addr = 3'd1;
        rq = 1'b1;
        exp_q.push_back(make_row(16'h100, 1));
        tick();
        rq = 1'b0;
        rd_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk_row("stall_hold", rd_data, '0);
        end
        rd_en = 1'b1;
        repeat (3) tick();
        rd(0, make_row(16'h300, 0));
        rd(2, make_row(16'h100, 2));
        rd_addr = 3'd7;
        tick();
        repeat (3) tick();

        // load restarts at row 0, beat 0 after reset
        load_all(16'h400);
        chk("rst_reload_done", 32'(load_done), 1);
        chk("rst_reload_rows", 32'(rows_loaded), 3);
        for (int r = 0; r < RD; r++) rd(r, make_row(16'h400, r));
        repeat (4) tick();
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dense_weight_stream_loader.md
# dense_weight_stream_loader

Receive end of the weight-streaming interface. The block accepts weight beats on a valid/ready stream of `WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1` elements per beat and packs consecutive beats into full rows of `WEIGHT_TENSOR_SIZE_DIM_0` elements. It writes each row into an on-chip RAM and then serves registered reads to the dense datapath. It sits between an off-chip or host weight stream and the linear-layer compute, and replaces per-layer weight ROMs with a loadable store.

## Interface
Parameters:
- `WEIGHT_TENSOR_SIZE_DIM_0`, 32: elements per row.
- `WEIGHT_PRECISION_0`, 16: bits per element.
- `WEIGHT_PARALLELISM_DIM_0`, 4: beat parallelism, dim 0.
- `WEIGHT_PARALLELISM_DIM_1`, 1: beat parallelism, dim 1.
- `ROW_DEPTH`, 8: rows stored.
- `BEAT_ELEMS`, `WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1` (derived).
- `BEATS_PER_ROW`, `WEIGHT_TENSOR_SIZE_DIM_0/BEAT_ELEMS` (derived; the division must be exact).
- `ROW_WIDTH`, `WEIGHT_PRECISION_0*WEIGHT_TENSOR_SIZE_DIM_0` (derived).
- `AWIDTH`, `$clog2(ROW_DEPTH)+1` (derived).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `data_in`, in, `[WEIGHT_PRECISION_0-1:0] x [BEAT_ELEMS]`: weight beat (unpacked array).
- `data_in_valid`, in, 1: beat valid.
- `data_in_ready`, out, 1: loader can accept a beat.
- `reload`, in, 1: single-cycle pulse that restarts loading from row 0.
- `load_done`, out, 1: all `ROW_DEPTH` rows have been written.
- `rows_loaded`, out, `AWIDTH`: count of rows written since the last reset or reload.
- `rd_addr`, in, `AWIDTH`: read row address.
- `rd_en`, in, 1: read/clock enable for the read pipeline.
- `rd_data`, out, `ROW_WIDTH`: row data.

## Operation
- FSM has two states:
  - LOAD: entered on reset or `reload`.
  - DONE: entered on the accepted last beat of row `ROW_DEPTH-1`. Only `reload` or `rst` leaves DONE.
- `data_in_ready` = (state==LOAD). It is combinational from state only and does not depend on `data_in_valid`.
- A transfer occurs on a cycle with `data_in_valid && data_in_ready && !reload`.
- `beat_cnt` runs 0..`BEATS_PER_ROW-1`; `row_cnt` runs 0..`ROW_DEPTH-1`.
- Beat packing: element j of beat b occupies row bits `[WEIGHT_PRECISION_0*(b*BEAT_ELEMS+j) +: WEIGHT_PRECISION_0]`.
- Beats 0..`BEATS_PER_ROW-2` are stored into a row buffer register.
- On the transfer of the final beat, the RAM is written at `row_cnt` with {current beat, buffer} merged in the same cycle. There is no extra cycle per row.
- After each row write, `beat_cnt` wraps to 0, `row_cnt` increments and `rows_loaded` increments.
- After row `ROW_DEPTH-1` is written, `row_cnt` wraps to 0 and the state goes to DONE.
- `reload` (any state): clears `beat_cnt`, `row_cnt`, `rows_loaded` and `load_done`, and sets state to LOAD. A beat presented in the same cycle is discarded, because `reload` has priority. RAM contents are not cleared.
- Read path: 2-stage pipeline, gated by `rd_en`.
  - Stage 0 registers `ram[rd_addr]`; stage 1 registers stage 0.
  - The RAM is read-first: a read and a write to the same row in the same cycle returns the old data.
  - Reads are legal in any state. Unwritten rows return undefined data.
  - `rd_addr >= ROW_DEPTH` returns undefined data and must not corrupt state.

## Timing
- Reset values: `data_in_ready`=1 (LOAD), `load_done`=0, `rows_loaded`=0, counters 0. The `rd_data` pipeline registers are cleared to 0.
- Reset mid-load: the partial row buffer is discarded, already-written RAM rows are retained, and loading restarts at row 0, beat 0.
- Input throughput: 1 beat/cycle sustained. Total load time = `ROW_DEPTH*BEATS_PER_ROW` accepted beats.
- `load_done` and DONE are registered: they rise the cycle after the final accepted beat, and `data_in_ready` falls in that same cycle.
- `rows_loaded` updates the cycle after each row write.
- Read latency: 2 `rd_en`-enabled cycles from `rd_addr` to `rd_data`. With `rd_en`=0 both stages hold.
- Row-write visibility: a row written at edge N is visible to a read issued at cycle N+1, with data appearing at N+3.
- `data_in_valid` gaps insert no state change; the counters hold.

## Test plan
- Config: P=16, TS0=8, PAR0=2, PAR1=1, `ROW_DEPTH`=3, so 4 beats/row and 12 beats total.
- Full load: stream elements with value = global element index 0..23, valid every cycle.
  - `data_in_ready` drops and `load_done`=1 one cycle after beat 12.
  - `rows_loaded`=3.
  - Reading row 1 gives `rd_data[15:0]`=0x0008 and `rd_data[127:112]`=0x000F, 2 cycles later.
- Bursty valid: same data with valid toggled 1,0,0,1… Final RAM contents are identical to the full-load case, and `rows_loaded` steps 1,2,3 only on row completion.
- Reload mid-row: after 6 beats, assert `reload` together with a valid beat.
  - The beat is dropped and `rows_loaded`=0.
  - A fresh 12-beat load of value 0x100+index makes row 0 element 0 read 0x0100.
- Read-first collision: read row 2 in the same cycle as its final write. Returns the old contents; re-reading the next cycle returns the new row.
- Reset mid-load plus `rd_en` stall:
  - `rst` after 5 beats gives ready=1, done=0, count=0, `rd_data`=0.
  - Holding `rd_en`=0 for 3 cycles after issuing a read freezes `rd_data`.
- Post-DONE: valid held high for 5 cycles in DONE is not accepted, leaving RAM and `rows_loaded` unchanged.
